uart_tx_arbiter: RTL and testbench

//  Round-robin arbiter sharing the UART transmit FIFO between NUM_REQ byte requesters.

---
 rtl/uart_tx_arbiter.sv | 110 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets one requester at a time push a whole message into the
// shared UART TX FIFO, so bytes from different clients never interleave on the line.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int MAX_BURST    = 16,
    parameter int IDLE_TIMEOUT = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_data,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int BW  = $clog2(MAX_BURST + 1);
    localparam int SW  = $clog2(IDLE_TIMEOUT + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                state;
    logic [IDW-1:0]        rr_ptr;
    logic [IDW-1:0]        sel;
    logic [IDW-1:0]        idx;
    logic [BW-1:0]         beat_cnt;
    logic [SW-1:0]         stall_cnt;
    logic [DATA_WIDTH-1:0] slice [NUM_REQ];
    logic                  g_valid;
    logic                  g_last;
    logic                  accept;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            slice[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Walk downward so the candidate closest after rr_ptr is the last one to win.
    always_comb begin
        sel = rr_ptr;
        idx = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = IDW'((int'(rr_ptr) + k) % NUM_REQ);
            if (req_valid[idx]) begin
                sel = idx;
            end
        end
    end

    assign g_valid = req_valid[grant_id];
    assign g_last  = req_last[grant_id];

    always_comb begin
        req_ready = '0;
        if (state == BURST && !rst) begin
            req_ready[grant_id] = !fifo_full;
        end
    end

    assign accept     = g_valid & req_ready[grant_id];
    assign fifo_wr_en = accept;
    assign fifo_data  = slice[grant_id];
    assign busy       = (state == BURST);

    // Backpressure with valid high is neither a beat nor a stall, so neither counter moves.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grant_id  <= '0;
            rr_ptr    <= IDW'(NUM_REQ - 1);
            beat_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        grant_id  <= sel;
                        rr_ptr    <= sel;
                        beat_cnt  <= '0;
                        stall_cnt <= '0;
                        state     <= BURST;
                    end
                end
                BURST: begin
                    if (accept) begin
                        beat_cnt  <= beat_cnt + 1'b1;
                        stall_cnt <= '0;
                        if (g_last || beat_cnt == BW'(MAX_BURST - 1)) begin
                            state <= IDLE;
                        end
                    end else if (!g_valid) begin
                        stall_cnt <= stall_cnt + 1'b1;
                        if (stall_cnt == SW'(IDLE_TIMEOUT - 1)) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: per-requester expected byte queues feed a
// monitor that applies the arbitration rules each cycle and compares every output.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ      = 4;
    localparam int DW           = 8;
    localparam int MAX_BURST    = 16;
    localparam int IDLE_TIMEOUT = 8;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ*DW-1:0]  req_data;
    logic [NUM_REQ-1:0]     req_last;
    logic [NUM_REQ-1:0]     req_ready;
    logic                   fifo_full;
    logic                   fifo_wr_en;
    logic [DW-1:0]          fifo_data;
    logic [1:0]             grant_id;
    logic                   busy;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .DATA_WIDTH   (DW),
        .MAX_BURST    (MAX_BURST),
        .IDLE_TIMEOUT (IDLE_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .fifo_full  (fifo_full),
        .fifo_wr_en (fifo_wr_en),
        .fifo_data  (fifo_data),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    int         n_vec;
    int         n_miss;
    logic [8:0] exp_q [NUM_REQ][$];
    logic [8:0] drv_q [NUM_REQ][$];
    int         drop_pct;
    int         full_pct;
    bit         force_full;
    bit         mon_en;
    int         dut_grants [$];
    int         dut_bursts [$];
    int         dut_writes;

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // One message: bytes base, base+step, ...; last flag only on the final byte if requested.
    task automatic apply_stimulus(input int id, input int len, input bit with_last,
                                  input logic [7:0] base, input logic [7:0] step);
        for (int b = 0; b < len; b++) begin
            logic [8:0] e;
            e[7:0] = base + 8'(b) * step;
            e[8]   = with_last && (b == len - 1);
            exp_q[id].push_back(e);
            drv_q[id].push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (drv_q[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        dut_grants.delete();
        dut_bursts.delete();
        dut_writes = 0;
    endtask

    task automatic drain(input string name, input int limit);
        int c;
        c = 0;
        while (c < limit && !(all_empty() && !busy)) begin
            tick();
            c++;
        end
        check_output({name, "_drained"}, 32'(c < limit), 1);
        tick();
        tick();
    endtask

    task automatic wait_writes(input int n);
        int c;
        c = 0;
        while (c < 500 && dut_writes < n) begin
            tick();
            c++;
        end
        check_output("wait_writes", 32'(dut_writes >= n), 1);
    endtask

    // Requester/FIFO driver: updates land 2 time units after the edge, after main's knobs.
    initial begin
        logic [NUM_REQ-1:0]    acc;
        logic [NUM_REQ-1:0]    nv;
        logic [NUM_REQ-1:0]    nl;
        logic [NUM_REQ*DW-1:0] nd;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        fifo_full = 1'b0;
        forever begin
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk);
            #2;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (acc[i] && drv_q[i].size() > 0) void'(drv_q[i].pop_front());
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (drv_q[i].size() > 0 && $urandom_range(0, 99) >= drop_pct) begin
                    nv[i]           = 1'b1;
                    nl[i]           = drv_q[i][0][8];
                    nd[i*DW +: DW]  = drv_q[i][0][7:0];
                end else begin
                    nv[i]           = 1'b0;
                    nl[i]           = 1'b0;
                    nd[i*DW +: DW]  = 8'($urandom);
                end
            end
            req_valid = nv;
            req_last  = nl;
            req_data  = nd;
            fifo_full = force_full || ($urandom_range(0, 99) < full_pct);
        end
    end

    // Monitor with reference model: grant goes to the first valid requester after the
    // previous winner; a burst ends on last, MAX_BURST beats or IDLE_TIMEOUT idle cycles.
    initial begin
        int                 m_busy, m_owner, m_ptr, m_beats, m_stall, c;
        bit                 found, exp_wr, exp_last, prev_busy;
        logic [NUM_REQ-1:0] exp_ready;
        logic [8:0]         ent;
        int                 cur_beats;
        m_busy = 0; m_owner = 0; m_ptr = NUM_REQ - 1; m_beats = 0; m_stall = 0;
        prev_busy = 1'b0; cur_beats = 0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                exp_ready = '0;
                exp_wr    = 1'b0;
                exp_last  = 1'b0;
                if (m_busy != 0 && !rst) begin
                    exp_ready[m_owner] = !fifo_full;
                    exp_wr             = req_valid[m_owner] && !fifo_full;
                end
                check_output("busy", 32'(busy), 32'(m_busy));
                check_output("grant_id", 32'(grant_id), 32'(m_owner));
                check_output("req_ready", 32'(req_ready), 32'(exp_ready));
                check_output("fifo_wr_en", 32'(fifo_wr_en), 32'(exp_wr));
                if (exp_wr) begin
                    if (exp_q[m_owner].size() > 0) begin
                        ent      = exp_q[m_owner].pop_front();
                        exp_last = ent[8];
                        check_output("fifo_data", 32'(fifo_data), 32'(ent[7:0]));
                    end else begin
                        check_output("exp_underflow", 1, 0);
                    end
                end

                if (busy && !prev_busy) begin
                    dut_grants.push_back(int'(grant_id));
                    cur_beats = 0;
                end
                if (fifo_wr_en) begin
                    dut_writes++;
                    cur_beats++;
                end
                if (!busy && prev_busy) dut_bursts.push_back(cur_beats);
                prev_busy = busy;

                if (rst) begin
                    m_busy = 0; m_owner = 0; m_ptr = NUM_REQ - 1;
                end else if (m_busy == 0) begin
                    if (req_valid != '0) begin
                        found = 1'b0;
                        for (int k = 1; k <= NUM_REQ; k++) begin
                            c = (m_ptr + k) % NUM_REQ;
                            if (!found && req_valid[c]) begin
                                m_owner = c;
                                found   = 1'b1;
                            end
                        end
                        m_ptr = m_owner; m_busy = 1; m_beats = 0; m_stall = 0;
                    end
                end else if (exp_wr) begin
                    m_beats++;
                    m_stall = 0;
                    if (exp_last || m_beats == MAX_BURST) m_busy = 0;
                end else if (!req_valid[m_owner]) begin
                    m_stall++;
                    if (m_stall == IDLE_TIMEOUT) m_busy = 0;
                end
            end
        end
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        n_vec = 0; n_miss = 0; dut_writes = 0;
        rst = 1'b1; drop_pct = 0; full_pct = 0; force_full = 1'b0; mon_en = 1'b0;
        tick();
        tick();
        mon_en = 1'b1;
        tick();
        rst = 1'b0;

        // Two single-byte messages: requester 0 wins first, then 2.
        apply_stimulus(0, 1, 1'b1, 8'hA0, 8'h00);
        apply_stimulus(2, 1, 1'b1, 8'hC0, 8'h00);
        drain("t1", 500);
        check_output("t1_grants", 32'(dut_grants.size()), 2);
        check_output("t1_first", 32'(dut_grants[0]), 0);
        check_output("t1_second", 32'(dut_grants[1]), 2);

        apply_reset();
        apply_stimulus(1, 3, 1'b1, 8'h11, 8'h11);
        apply_stimulus(3, 2, 1'b1, 8'h44, 8'h11);
        drain("t2", 500);
        check_output("t2_first", 32'(dut_grants[0]), 1);
        check_output("t2_second", 32'(dut_grants[1]), 3);
        check_output("t2_burst0", 32'(dut_bursts[0]), 3);

        // 20 bytes without last: forced release at 16, regrant, then idle timeout.
        apply_reset();
        apply_stimulus(0, 20, 1'b0, 8'h01, 8'h01);
        drain("t3", 500);
        check_output("t3_grants", 32'(dut_grants.size()), 2);
        check_output("t3_regrant", 32'(dut_grants[1]), 0);
        check_output("t3_burst0", 32'(dut_bursts[0]), MAX_BURST);
        check_output("t3_burst1", 32'(dut_bursts[1]), 4);

        // FIFO full longer than the idle timeout must not split the message.
        apply_reset();
        apply_stimulus(0, 6, 1'b1, 8'h60, 8'h01);
        wait_writes(2);
        force_full = 1'b1;
        repeat (10) tick();
        force_full = 1'b0;
        drain("t4", 500);
        check_output("t4_grants", 32'(dut_grants.size()), 1);
        check_output("t4_burst0", 32'(dut_bursts[0]), 6);

        apply_reset();
        apply_stimulus(0, 1, 1'b0, 8'h3C, 8'h00);
        apply_stimulus(2, 1, 1'b1, 8'h5A, 8'h00);
        drain("t5", 500);
        check_output("t5_first", 32'(dut_grants[0]), 0);
        check_output("t5_second", 32'(dut_grants[1]), 2);
        check_output("t5_burst0", 32'(dut_bursts[0]), 1);

        // Reset mid-burst: nothing written in the reset cycle, idle afterwards.
        apply_reset();
        apply_stimulus(0, 10, 1'b1, 8'hB0, 8'h01);
        wait_writes(2);
        rst = 1'b1;
        @(negedge clk);
        check_output("t6_rst_wr", 32'(fifo_wr_en), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_output("t6_busy", 32'(busy), 0);
        check_output("t6_wr", 32'(fifo_wr_en), 0);
        check_output("t6_grant", 32'(grant_id), 0);
        drain("t6", 500);
        check_output("t6_writes", 32'(dut_writes), 10);

        apply_reset();
        drop_pct = 15;
        full_pct = 25;
        for (int m = 0; m < 40; m++) begin
            apply_stimulus($urandom_range(0, NUM_REQ - 1), $urandom_range(1, 20),
                           $urandom_range(0, 9) != 0, 8'($urandom), 8'($urandom));
            repeat ($urandom_range(0, 12)) tick();
        end
        drain("random", 6000);
        drop_pct = 0;
        full_pct = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            check_output("exp_q_empty", 32'(exp_q[i].size()), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
